// File: rtl/track_sequencer.sv
// track_sequencer: playback controller for the MP3 player.
// Owns the current track index, the elapsed play time and the per-track
// length table, and sequences track changes from the next/prev buttons and
// from automatic end-of-track advance. track_start restarts the decoder.
//
// Optional feature: define TRACK_SEQ_REPEAT_EN to add the repeat_mode input
// (0 = normal, 1 = repeat-one, 2 = stop after the last track, 3 = normal).
module track_sequencer #(
  parameter int NUM_TRACKS       = 4,
  parameter int TICK_DIV         = 100000000,
  parameter int DEFAULT_LEN_SEC  = 75,
  parameter int PREV_RESTART_SEC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_pause,
  input  logic        stop,
  input  logic        next,
  input  logic        prev,
  input  logic        len_wr_en,
  input  logic [3:0]  len_wr_addr,
  input  logic [11:0] len_wr_sec,
`ifdef TRACK_SEQ_REPEAT_EN
  input  logic [1:0]  repeat_mode,
`endif
  output logic [3:0]  track_idx,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic        playing,
  output logic        track_start,
  output logic        track_end
);

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;

  localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_IDX    = 4'(NUM_TRACKS - 1);
  localparam logic [11:0]   DEFAULT_LEN = 12'(DEFAULT_LEN_SEC);
  localparam logic [11:0]   RESTART_SEC = 12'(PREV_RESTART_SEC);

  logic [1:0]    state_q,   state_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [11:0]   elapsed_q, elapsed_d;
  logic [7:0]    sec_q,     sec_d;
  logic [7:0]    min_q,     min_d;
  logic [3:0]    idx_q,     idx_d;
  logic          playing_q, playing_d;
  logic          start_q,   start_d;
  logic          end_q,     end_d;
  logic [11:0]   len_q [NUM_TRACKS];

  logic          tick;
  logic          at_end;
  logic          clear_time;
  logic [11:0]   cur_len;
  logic [3:0]    idx_inc;
  logic [3:0]    idx_dec;

  // Look up the current track's length and the neighbouring track indices.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    cur_len = DEFAULT_LEN;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      if (idx_q == 4'(i)) cur_len = len_q[i];
    end
    idx_inc = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
    idx_dec = (idx_q == 4'd0) ? LAST_IDX : idx_q - 4'd1;
    tick    = (state_q == ST_PLAYING) && (presc_q == PRESC_MAX);
    at_end  = tick && (({1'b0, elapsed_q} + 13'd1) >= {1'b0, cur_len});
  end

  // Next-state logic: one event per cycle in priority stop > next > prev >
  // play_pause > end/tick; lower-priority coincident events are dropped.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    elapsed_d  = elapsed_q;
    sec_d      = sec_q;
    min_d      = min_q;
    idx_d      = idx_q;
    start_d    = 1'b0;
    end_d      = 1'b0;
    clear_time = 1'b0;

    if (stop) begin
      state_d    = ST_STOPPED;
      clear_time = 1'b1;
    end else if (next) begin
      idx_d      = idx_inc;
      clear_time = 1'b1;
      start_d    = (state_q != ST_STOPPED);
    end else if (prev) begin
      // Late in a track prev restarts it; early on it steps back one track.
      if (elapsed_q < RESTART_SEC) idx_d = idx_dec;
      clear_time = 1'b1;
      start_d    = (state_q != ST_STOPPED);
    end else if (play_pause) begin
      case (state_q)
        ST_STOPPED: begin
          state_d    = ST_PLAYING;
          start_d    = 1'b1;
          clear_time = 1'b1;
        end
        ST_PLAYING: state_d = ST_PAUSED;
        ST_PAUSED:  state_d = ST_PLAYING;
        default:    state_d = ST_STOPPED;
      endcase
    end else if (at_end) begin
      end_d      = 1'b1;
      start_d    = 1'b1;
      clear_time = 1'b1;
      idx_d      = idx_inc;
`ifdef TRACK_SEQ_REPEAT_EN
      case (repeat_mode)
        2'd1: idx_d = idx_q;
        2'd2: begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOPPED;
            idx_d   = 4'd0;
            start_d = 1'b0;
          end
        end
        default: idx_d = idx_inc;
      endcase
`endif
    end else if (tick) begin
      presc_d   = '0;
      elapsed_d = elapsed_q + 12'd1;
      if (sec_q == 8'd59) begin
        sec_d = 8'd0;
        min_d = (min_q == 8'd255) ? min_q : min_q + 8'd1;
      end else begin
        sec_d = sec_q + 8'd1;
      end
    end else if (state_q == ST_PLAYING) begin
      presc_d = presc_q + PW'(1);
    end

    if (clear_time) begin
      presc_d   = '0;
      elapsed_d = '0;
      sec_d     = '0;
      min_d     = '0;
    end

    playing_d = (state_d == ST_PLAYING);
  end

  // Control and time registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_STOPPED;
      presc_q   <= '0;
      elapsed_q <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      idx_q     <= '0;
      playing_q <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      idx_q     <= idx_d;
      playing_q <= playing_d;
      start_q   <= start_d;
      end_q     <= end_d;
    end
  end

  // Track length table: reloaded with the default on reset, written by len_wr_*.
  always_ff @(posedge clk) begin
    // NOTE: this table is reset deliberately because every entry has a defined
    // power-on length; it is small, so it stays in flops rather than RAM.
    if (rst) begin
      for (int i = 0; i < NUM_TRACKS; i++) len_q[i] <= DEFAULT_LEN;
    end else if (len_wr_en) begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        if (len_wr_addr == 4'(i)) len_q[i] <= (len_wr_sec == 12'd0) ? 12'd1 : len_wr_sec;
      end
    end
  end

  assign track_idx   = idx_q;
  assign minute      = min_q;
  assign second      = sec_q;
  assign playing     = playing_q;
  assign track_start = start_q;
  assign track_end   = end_q;

endmodule
